ab_sequence_driver: RTL and testbench
=====================================

// Module: ab_sequence_driver
// PURPOSE
//   Stimulus-side counterpart to the "a followed by b" cover/assume checks.
//   On a start pulse it drives a, then drives b exactly DELAY cycles later (a ##DELAY b).
//   Optional modes: A_HOLD keeps a high once it rises; B_HOLD keeps b high once asserted.
//   Sits in the formal/sim harness between the test sequencer and the property module.
// PARAMETERS
//   DELAY   default 1   cycles from a's first high cycle to b's first high cycle; legal 1..15
//   A_HOLD  default 0   1: a stays high from its first cycle through the first b cycle
//   B_HOLD  default 0   1: b stays high after asserting, until clear or rst
//   CNT_W   default 8   width of the completed-sequence counter
// PORTS
//   clk     in   1      single clock; all logic on posedge
//   rst     in   1      synchronous, active-high reset
//   start   in   1      request one a ##DELAY b sequence; sampled only in IDLE
//   abort   in   1      cancel a sequence in progress (A or WAIT states)
//   clear   in   1      release sticky b (B_HOLD=1 only)
//   a       out  1      registered sequence output a
//   b       out  1      registered sequence output b
//   busy    out  1      high in any state other than IDLE
//   done    out  1      one-cycle pulse coincident with b's first high cycle
//   seq_cnt out  CNT_W  number of completed sequences, saturating at all-ones
// BEHAVIOUR
//   - Reset: state=IDLE; a=0, b=0, busy=0, done=0, seq_cnt=0; rst wins over every input.
//   - All outputs are registered; no combinational path from any input to any output.
//   - States: IDLE, A, WAIT, B, STICKY.
//   - IDLE: start=1 and abort=0 at edge k -> state A; a=1 in cycle k+1.
//   - A: a=1 for one cycle; load counter with DELAY-1.
//       DELAY=1 -> B next cycle. Otherwise -> WAIT.
//   - WAIT: counter decrements each cycle; at 0 -> B.
//       a=A_HOLD during WAIT; b=0.
//   - Timing: a first high in cycle k+1, b first high in cycle k+1+DELAY. No other cycle has b rising.
//   - B: b=1, done=1, seq_cnt+=1 (saturating); a=A_HOLD in this cycle.
//       B_HOLD=0 -> IDLE next cycle.
//       B_HOLD=1 -> STICKY.
//   - STICKY: b=1, a=0, busy=1, done=0; start ignored; clear=1 -> IDLE next cycle (b=0).
//   - abort in A or WAIT -> IDLE next cycle; a=0, b=0, no done, seq_cnt unchanged.
//     abort in B, STICKY or IDLE is ignored.
//   - start while busy: ignored, not queued.
//     start and abort together in IDLE: abort wins, stays IDLE.
//   - clear outside STICKY: ignored.
//   - Back-to-back: with B_HOLD=0, start sampled in the cycle after B begins a new sequence.
//     The minimum gap between successive b pulses is DELAY+2 cycles.
//   - rst mid-sequence: outputs 0 next cycle, seq_cnt=0, no done.
//   - DELAY outside 1..15: elaboration error ($error in a generate check).
// TESTING
//   - DELAY=1, start at cycle 2 -> a=1 at cycle 3 only; b=1, done=1 at cycle 4; seq_cnt=1.
//   - DELAY=3, A_HOLD=1, start at cycle 2 -> a=1 cycles 3..6; b=1 cycle 6 only; busy high 3..6.
//   - DELAY=3, abort at cycle 4 after start at cycle 2 -> a=0, b=0 from cycle 5; seq_cnt stays 0.
//   - B_HOLD=1, DELAY=2, start at cycle 2 -> b=1 from cycle 5; start at cycle 8 ignored;
//     clear at cycle 10 -> b=0 at cycle 11.
//   - CNT_W=2, DELAY=1: run 5 sequences -> seq_cnt=3 after the 3rd and stays 3; rst -> 0.
//   - Formal: bind the a/b cover properties; a ##DELAY b is covered, and the A_HOLD and B_HOLD
//     assumptions are never violated.

Source files
------------

// File: rtl/ab_sequence_driver.sv
// ab_sequence_driver: drives a, then b exactly DELAY cycles later (a ##DELAY b),
// with optional hold of a until b (A_HOLD) and sticky b until clear (B_HOLD).
// Every output is a register; nothing combinational reaches an output port.
module ab_sequence_driver #(
    parameter int DELAY  = 1,
    parameter int A_HOLD = 0,
    parameter int B_HOLD = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             clear,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] seq_cnt
);

    // The gap counter is 4 bits wide, so DELAY must stay within 1..15.
    generate
        if (DELAY < 1 || DELAY > 15) begin : g_bad_delay
            $error("ab_sequence_driver: DELAY must be in 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_A,
        S_WAIT,
        S_B,
        S_STICKY
    } state_t;

    // Loaded on entry to A; A and WAIT together last DELAY cycles before B.
    localparam logic [3:0] LOAD       = 4'(DELAY - 1);
    localparam logic       A_HOLD_BIT = (A_HOLD != 0);

    state_t     state;
    logic [3:0] gap_cnt;

    // Completed-sequence count, held at all-ones once it gets there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Sequence FSM with registered a/b/busy/done/seq_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            seq_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // abort beats start in IDLE; otherwise start launches a sequence.
                    if (start && !abort) begin
                        state   <= S_A;
                        gap_cnt <= LOAD;
                        a       <= 1'b1;
                        b       <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                S_A, S_WAIT: begin
                    if (abort) begin
                        state <= S_IDLE;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                    end else if (gap_cnt == 4'd0) begin
                        // b's first cycle: done pulses and the count advances here.
                        state   <= S_B;
                        a       <= A_HOLD_BIT;
                        b       <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b1;
                        seq_cnt <= sat_inc(seq_cnt);
                    end else begin
                        state   <= S_WAIT;
                        gap_cnt <= gap_cnt - 4'd1;
                        a       <= A_HOLD_BIT;
                        b       <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                S_B: begin
                    // Sticky mode parks with b high; otherwise return to IDLE so a
                    // start in the following cycle can launch the next sequence.
                    if (B_HOLD != 0) begin
                        state <= S_STICKY;
                        a     <= 1'b0;
                        b     <= 1'b1;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                    end
                end

                S_STICKY: begin
                    if (clear) begin
                        state <= S_IDLE;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        a    <= 1'b0;
                        b    <= 1'b1;
                        busy <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    a     <= 1'b0;
                    b     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ab_sequence_driver.sv
// Testbench for ab_sequence_driver: three instances with different parameter
// sets driven by one directed sequence; expected done cycles are queued when
// start is driven and popped whenever a done pulse appears.
module tb_ab_sequence_driver;

    logic clk = 1'b0;
    logic rst;

    logic start1, abort1, clear1, a1, b1, busy1, done1;
    logic [1:0] cnt1;
    logic start3, abort3, clear3, a3, b3, busy3, done3;
    logic [7:0] cnt3;
    logic starth, aborth, clearh, ah, bh, busyh, doneh;
    logic [7:0] cnth;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int q1[$];
    int q3[$];
    int qh[$];

    always #5 clk = ~clk;

    ab_sequence_driver #(.DELAY(1), .A_HOLD(0), .B_HOLD(0), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .clear(clear1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .seq_cnt(cnt1)
    );

    ab_sequence_driver #(.DELAY(3), .A_HOLD(1), .B_HOLD(0), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .clear(clear3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .seq_cnt(cnt3)
    );

    ab_sequence_driver #(.DELAY(2), .A_HOLD(0), .B_HOLD(1), .CNT_W(8)) uh (
        .clk(clk), .rst(rst), .start(starth), .abort(aborth), .clear(clearh),
        .a(ah), .b(bh), .busy(busyh), .done(doneh), .seq_cnt(cnth)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk1(input string t, input logic ea, input logic eb, input logic ebusy, input int ecnt);
        chk({t, ".a1"}, 32'(a1), 32'(ea));
        chk({t, ".b1"}, 32'(b1), 32'(eb));
        chk({t, ".busy1"}, 32'(busy1), 32'(ebusy));
        chk({t, ".cnt1"}, 32'(cnt1), 32'(ecnt));
    endtask

    task automatic chk3(input string t, input logic ea, input logic eb, input logic ebusy, input int ecnt);
        chk({t, ".a3"}, 32'(a3), 32'(ea));
        chk({t, ".b3"}, 32'(b3), 32'(eb));
        chk({t, ".busy3"}, 32'(busy3), 32'(ebusy));
        chk({t, ".cnt3"}, 32'(cnt3), 32'(ecnt));
    endtask

    task automatic chkh(input string t, input logic ea, input logic eb, input logic ebusy, input int ecnt);
        chk({t, ".ah"}, 32'(ah), 32'(ea));
        chk({t, ".bh"}, 32'(bh), 32'(eb));
        chk({t, ".busyh"}, 32'(busyh), 32'(ebusy));
        chk({t, ".cnth"}, 32'(cnth), 32'(ecnt));
    endtask

    // Scoreboard side: every done pulse must match the oldest queued cycle.
    task automatic mon();
        if (done1 === 1'b1) begin
            if (q1.size() == 0) chk("done1_unexpected", 32'(1), 32'(0));
            else chk("done1_cycle", 32'(cyc), 32'(q1.pop_front()));
        end
        if (done3 === 1'b1) begin
            if (q3.size() == 0) chk("done3_unexpected", 32'(1), 32'(0));
            else chk("done3_cycle", 32'(cyc), 32'(q3.pop_front()));
        end
        if (doneh === 1'b1) begin
            if (qh.size() == 0) chk("doneh_unexpected", 32'(1), 32'(0));
            else chk("doneh_cycle", 32'(cyc), 32'(qh.pop_front()));
        end
    endtask

    // Advance one clock; outputs of the new cycle are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mon();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start1 = 0; abort1 = 0; clear1 = 0;
        start3 = 0; abort3 = 0; clear3 = 0;
        starth = 0; aborth = 0; clearh = 0;
        tick();
        tick();
        rst = 1'b0;
        chk1("reset", 0, 0, 0, 0);
        chk3("reset", 0, 0, 0, 0);
        chkh("reset", 0, 0, 0, 0);
        chk("reset.done", 32'({done1, done3, doneh}), 32'(0));

        // Start all three in cycle 2; b expected at 2+1+DELAY.
        q1.push_back(4);
        q3.push_back(6);
        qh.push_back(5);
        for (int c = 2; c <= 11; c++) begin
            start1 = (c == 2);
            start3 = (c == 2);
            starth = (c == 2) || (c == 8);
            clearh = (c == 10);
            tick();
            n = c + 1;
            chk1("basic", n == 3, n == 4, n == 3 || n == 4, (n >= 4) ? 1 : 0);
            chk3("ahold", n >= 3 && n <= 6, n == 6, n >= 3 && n <= 6, (n >= 6) ? 1 : 0);
            chkh("bhold", n == 3, n >= 5 && n <= 10, n >= 3 && n <= 10, (n >= 5) ? 1 : 0);
        end
        start1 = 0; starth = 0; clearh = 0;

        // Cycle 12: u3 abort in WAIT, u1 abort in A.
        start3 = 1; start1 = 1;
        tick();                              // 13
        start3 = 0; start1 = 0; abort1 = 1;
        chk1("abortA.pre", 1, 0, 1, 1);
        tick();                              // 14
        abort1 = 0;
        chk1("abortA.post", 0, 0, 0, 1);
        chk3("abortW.pre", 1, 0, 1, 1);
        abort3 = 1;
        tick();                              // 15
        abort3 = 0;
        chk3("abortW.post", 0, 0, 0, 1);
        start1 = 1; abort1 = 1;              // start+abort in IDLE: abort wins
        tick();                              // 16
        start1 = 0; abort1 = 0;
        chk1("start_abort", 0, 0, 0, 1);
        tick();                              // 17
        chk3("abortW.late", 0, 0, 0, 1);
        chk1("start_abort.late", 0, 0, 0, 1);

        // clear outside STICKY is ignored; clear in STICKY releases b.
        starth = 1; clearh = 1;
        qh.push_back(20);
        tick();                              // 18
        starth = 0;
        chkh("clr_ign.A", 1, 0, 1, 1);
        tick();                              // 19
        chkh("clr_ign.W", 0, 0, 1, 1);
        tick();                              // 20
        clearh = 0;
        chkh("clr_ign.B", 0, 1, 1, 2);
        tick();                              // 21
        chkh("sticky", 0, 1, 1, 2);
        clearh = 1;
        tick();                              // 22
        clearh = 0;
        chkh("clr_rel", 0, 0, 0, 2);

        // Back-to-back with start held: b every DELAY+2 = 3 cycles; counter saturates at 3.
        q1.push_back(24); q1.push_back(27); q1.push_back(30); q1.push_back(33);
        for (int c = 22; c <= 35; c++) begin
            start1 = (c <= 31);
            tick();
            n = c + 1;
            chk1("b2b",
                 n == 23 || n == 26 || n == 29 || n == 32,
                 n == 24 || n == 27 || n == 30 || n == 33,
                 (n >= 23 && n <= 24) || (n >= 26 && n <= 27) ||
                 (n >= 29 && n <= 30) || (n >= 32 && n <= 33),
                 (n < 24) ? 1 : (n < 27) ? 2 : 3);
        end
        start1 = 0;

        // Reset in the middle of a u3 sequence (cycle 36).
        start3 = 1;
        tick();                              // 37: A
        start3 = 0;
        tick();                              // 38: WAIT
        chk3("rst_mid.pre", 1, 0, 1, 1);
        rst = 1;
        tick();                              // 39
        chk1("rst_mid", 0, 0, 0, 0);
        chk3("rst_mid", 0, 0, 0, 0);
        chkh("rst_mid", 0, 0, 0, 0);
        rst = 0;
        tick();
        tick();
        chk3("rst_mid.after", 0, 0, 0, 0);
        chk1("rst_mid.after", 0, 0, 0, 0);

        chk("q1_left", 32'(q1.size()), 32'(0));
        chk("q3_left", 32'(q3.size()), 32'(0));
        chk("qh_left", 32'(qh.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
